// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_pkg : shared instruction-memory constants, loader states, and   |
// |            the big-endian byte select.           Rev 1.0             |
// +----------------------------------------------------------------------+
package imem_pkg;

  localparam int IMEM_BYTES  = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WR0    = 3'd2,
    ST_WR1    = 3'd3,
    ST_WR2    = 3'd4,
    ST_WR3    = 3'd5,
    ST_FIN    = 3'd6
  } loader_state_e;

  // Byte idx 0 is the most significant byte (lowest address).
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[31 - 8*int'(idx) -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader : streams 32-bit words into byte-wide instruction memory,|
// |               big-endian, one byte per cycle.    Rev 1.0             |
// +----------------------------------------------------------------------+
module imem_loader #(
  parameter int IMEM_BYTES = imem_pkg::IMEM_BYTES,
  parameter int ADDR_W     = 64,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count
);
  import imem_pkg::*;

  // One extra bit so an end address past the top can never wrap back into range.
  localparam logic [ADDR_W:0] c_word_off = (ADDR_W+1)'(INSTR_BYTES - 1);
  localparam logic [ADDR_W:0] c_mem_top  = (ADDR_W+1)'(IMEM_BYTES - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   w_end_addr;
  logic [1:0]        w_byte_idx;

  assign w_end_addr = {1'b0, addr_q} + c_word_off;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    last_d  = last_q;
    error_d = error_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          cnt_d   = '0;
          addr_d  = base_addr;
          if (base_addr[1:0] != 2'b00) begin
            error_d = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          word_d = in_word;
          last_d = in_last;
          if (w_end_addr > c_mem_top) begin
            error_d = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_WR0;
          end
        end
      end
      ST_WR0: state_d = ST_WR1;
      ST_WR1: state_d = ST_WR2;
      ST_WR2: state_d = ST_WR3;
      ST_WR3: begin
        addr_d  = addr_q + ADDR_W'(INSTR_BYTES);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last_q ? ST_FIN : ST_ACCEPT;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from the next state so they leave a flop.
    case (state_d)
      ST_WR1:  w_byte_idx = 2'd1;
      ST_WR2:  w_byte_idx = 2'd2;
      ST_WR3:  w_byte_idx = 2'd3;
      default: w_byte_idx = 2'd0;
    endcase

    wr_en_d    = (state_d == ST_WR0) || (state_d == ST_WR1) ||
                 (state_d == ST_WR2) || (state_d == ST_WR3);
    wr_addr_d  = wr_en_d ? (addr_d + ADDR_W'(w_byte_idx)) : '0;
    wr_data_d  = wr_en_d ? be_byte(word_d, w_byte_idx) : 8'h00;
    in_ready_d = (state_d == ST_ACCEPT);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      last_q     <= last_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader : directed stimulus against a cycle-timeline model.   |
// |                                                  Rev 1.0             |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_last = 1'b0;
  logic        in_ready, wr_en, busy, done, error;
  logic [63:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  word_count;

  imem_loader dut (
    .clk(clk), .reset(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mn;

  // Expected outputs per cycle, indexed by the clock edge that starts the cycle.
  bit          e_rdy[MAXC], e_busy[MAXC], e_done[MAXC], e_wr[MAXC], e_err[MAXC];
  logic [63:0] e_addr[MAXC];
  logic [7:0]  e_data[MAXC];
  int          e_cnt[MAXC];
  bit          p_cnt_v[MAXC];
  int          p_cnt[MAXC];
  longint unsigned m_addr = 0;

  logic [7:0]  mem_seen[64];
  int          wr_seen = 0;
  int          wr_mark;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d, t=%0t)", name, got, want, cyc, $time);
    end
  endtask

  // Timeline model: a session opens on start, each word occupies four write cycles.
  always @(posedge clk) begin
    if (!rst) begin
      cyc = cyc + 1;
      mn  = cyc;
      e_err[mn] = e_err[mn-1];
      e_cnt[mn] = p_cnt_v[mn] ? p_cnt[mn] : e_cnt[mn-1];
      if (!e_busy[mn-1] && start) begin
        e_err[mn]  = 1'b0;
        e_cnt[mn]  = 0;
        m_addr     = base_addr;
        e_busy[mn] = 1'b1;
        if (base_addr[1:0] != 2'b00) begin
          e_err[mn]  = 1'b1;
          e_done[mn] = 1'b1;
        end else begin
          e_rdy[mn] = 1'b1;
        end
      end else if (e_rdy[mn-1]) begin
        e_busy[mn] = 1'b1;
        if (!in_valid) begin
          e_rdy[mn] = 1'b1;
        end else if (m_addr + 3 > 63) begin
          e_err[mn]  = 1'b1;
          e_done[mn] = 1'b1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            e_busy[mn+k] = 1'b1;
            e_wr[mn+k]   = 1'b1;
            e_addr[mn+k] = m_addr + 64'(k);
            e_data[mn+k] = in_word[31-8*k -: 8];
          end
          e_busy[mn+4]  = 1'b1;
          p_cnt_v[mn+4] = 1'b1;
          p_cnt[mn+4]   = e_cnt[mn] + 1;
          if (in_last) e_done[mn+4] = 1'b1;
          else         e_rdy[mn+4]  = 1'b1;
          m_addr = m_addr + 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (cyc > 0) begin
        chk("wr_en", {63'd0, wr_en}, {63'd0, e_wr[cyc]});
        if (e_wr[cyc]) begin
          chk("wr_addr", wr_addr, e_addr[cyc]);
          chk("wr_data", {56'd0, wr_data}, {56'd0, e_data[cyc]});
        end
        chk("in_ready", {63'd0, in_ready}, {63'd0, e_rdy[cyc]});
        chk("busy", {63'd0, busy}, {63'd0, e_busy[cyc]});
        chk("done", {63'd0, done}, {63'd0, e_done[cyc]});
        chk("error", {63'd0, error}, {63'd0, e_err[cyc]});
        chk("word_count", {59'd0, word_count}, 64'(e_cnt[cyc]));
      end
      if (wr_en) begin
        mem_seen[wr_addr[5:0]] = wr_data;
        wr_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_word  = w;
    in_last  = l;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake: in_ready got 0 want 1 within 50 cycles (word %h)", w);
    end
    tick();
    if (l) in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 40) begin
      tick();
      t++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: done got 0 want 1 within 40 cycles", name);
    end
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_error"}, {63'd0, error}, 64'd0);
    chk({tag, "_wr_addr"}, wr_addr, 64'd0);
    chk({tag, "_wr_data"}, {56'd0, wr_data}, 64'd0);
    chk({tag, "_word_count"}, {59'd0, word_count}, 64'd0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout: simulation time got 100000 want finish earlier");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_seen[i] = 8'h00;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // 1: single word at base 0
    wr_mark = wr_seen;
    do_start(64'd0);
    send_word(32'hF8400142, 1'b1);
    wait_done("t1_done");
    chk("t1_mem0", {56'd0, mem_seen[0]}, 64'hF8);
    chk("t1_mem1", {56'd0, mem_seen[1]}, 64'h40);
    chk("t1_mem2", {56'd0, mem_seen[2]}, 64'h01);
    chk("t1_mem3", {56'd0, mem_seen[3]}, 64'h42);
    chk("t1_count", {59'd0, word_count}, 64'd1);
    chk("t1_writes", 64'(wr_seen - wr_mark), 64'd4);

    // 2: two words back-to-back with in_valid held high
    wr_mark = wr_seen;
    do_start(64'd8);
    send_word(32'hCB020064, 1'b0);
    send_word(32'h8B020065, 1'b1);
    wait_done("t2_done");
    chk("t2_mem8", {56'd0, mem_seen[8]}, 64'hCB);
    chk("t2_mem11", {56'd0, mem_seen[11]}, 64'h64);
    chk("t2_mem12", {56'd0, mem_seen[12]}, 64'h8B);
    chk("t2_mem15", {56'd0, mem_seen[15]}, 64'h65);
    chk("t2_count", {59'd0, word_count}, 64'd2);
    chk("t2_error", {63'd0, error}, 64'd0);
    chk("t2_writes", 64'(wr_seen - wr_mark), 64'd8);

    // 3: last legal slot, then overflow
    wr_mark = wr_seen;
    do_start(64'd60);
    send_word(32'h8B010008, 1'b0);
    send_word(32'h14000003, 1'b1);
    wait_done("t3_done");
    chk("t3_mem60", {56'd0, mem_seen[60]}, 64'h8B);
    chk("t3_mem63", {56'd0, mem_seen[63]}, 64'h08);
    chk("t3_error", {63'd0, error}, 64'd1);
    chk("t3_count", {59'd0, word_count}, 64'd1);
    chk("t3_writes", 64'(wr_seen - wr_mark), 64'd4);

    // 4: misaligned base, then a clean start clears error
    wr_mark = wr_seen;
    do_start(64'd2);
    chk("t4_done_now", {63'd0, done}, 64'd1);
    chk("t4_error", {63'd0, error}, 64'd1);
    wait_done("t4_done");
    chk("t4_error_idle", {63'd0, error}, 64'd1);
    chk("t4_writes", 64'(wr_seen - wr_mark), 64'd0);
    do_start(64'd0);
    chk("t4_error_cleared", {63'd0, error}, 64'd0);
    send_word(32'h11223344, 1'b1);
    wait_done("t4b_done");

    // 5: asynchronous reset in the middle of a word
    do_start(64'd0);
    send_word(32'hAA030046, 1'b1);
    tick();
    rst = 1'b1;
    for (int i = cyc; i < MAXC; i++) begin
      e_rdy[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_wr[i] = 1'b0;
      e_err[i] = 1'b0; e_cnt[i] = 0; p_cnt_v[i] = 1'b0;
    end
    #1;
    chk_all_zero("t5_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'h55555555;
    in_last  = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t5_mem0", {56'd0, mem_seen[0]}, 64'hAA);
    chk("t5_mem1", {56'd0, mem_seen[1]}, 64'h22);

    // 6: start pulsed mid-word is ignored
    wr_mark = wr_seen;
    do_start(64'd16);
    send_word(32'h12345678, 1'b1);
    tick();
    tick();
    start = 1'b1;
    base_addr = 64'd32;
    tick();
    start = 1'b0;
    wait_done("t6_done");
    chk("t6_mem16", {56'd0, mem_seen[16]}, 64'h12);
    chk("t6_mem19", {56'd0, mem_seen[19]}, 64'h78);
    chk("t6_mem32", {56'd0, mem_seen[32]}, 64'h00);
    chk("t6_count", {59'd0, word_count}, 64'd1);
    chk("t6_writes", 64'(wr_seen - wr_mark), 64'd4);
    chk("t6_busy_idle", {63'd0, busy}, 64'd0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
